// File: rtl/adc_serial_receiver.sv
`default_nettype none
// ============================================================================
// Module  : adc_serial_receiver
// Brief   : Paces the ADC clock generator and deserialises the ADC data line.
// Rev     : 1.0  initial release
// ============================================================================
module adc_serial_receiver #(
    parameter int DATA_WIDTH  = 12,
    parameter int HALF_PERIOD = 25,
    parameter int MSB_FIRST   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_tx,
    input  logic                  clk_adc,
    input  logic                  adc_dout,
    output logic                  wait_tx,
    output logic                  eoc_signal,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int c_HC_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int c_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [c_HC_W-1:0]  c_HC_MAX   = c_HC_W'(HALF_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_HC_W-1:0]     r_hc;
    logic                  r_wait;
    logic                  r_clk_adc_q;
    logic                  w_rise;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_sh;
    logic [DATA_WIDTH-1:0] w_sh_shifted;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_eoc;
    logic                  w_sample;
    logic                  w_clear;
    logic                  w_complete;
    logic                  w_eoc_next;
    logic                  w_invalid;

    assign w_rise = clk_adc & ~r_clk_adc_q;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sh_shifted = {r_sh[DATA_WIDTH-2:0], adc_dout};
        end else begin : g_lsb_first
            assign w_sh_shifted = {adc_dout, r_sh[DATA_WIDTH-1:1]};
        end
    endgenerate

    // Pacing tick: one registered pulse per HALF_PERIOD cycles while clocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hc   <= '0;
            r_wait <= 1'b0;
        end else if (!start_tx) begin
            r_hc   <= '0;
            r_wait <= 1'b0;
        end else begin
            r_wait <= (r_hc == c_HC_MAX);
            r_hc   <= (r_hc == c_HC_MAX) ? '0 : r_hc + c_HC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_clear      = 1'b0;
        w_complete   = 1'b0;
        w_eoc_next   = 1'b0;
        w_invalid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The generator raises start_tx with the first clk_adc edge.
                if (start_tx) begin
                    w_state_next = S_SHIFT;
                    w_sample     = w_rise;
                end
            end
            S_SHIFT: begin
                if (!start_tx) begin
                    w_state_next = S_IDLE;
                    w_clear      = 1'b1;
                end else if (w_rise) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_complete   = 1'b1;
                        w_eoc_next   = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!start_tx) begin
                    w_state_next = S_IDLE;
                    w_clear      = 1'b1;
                end else begin
                    w_eoc_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_clear      = 1'b1;
                w_invalid    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_adc_q  <= 1'b0;
            r_sh         <= '0;
            r_bit_cnt    <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_eoc        <= 1'b0;
        end else begin
            r_clk_adc_q  <= clk_adc;
            r_data_valid <= w_complete;
            r_eoc        <= w_eoc_next;
            if (w_clear) begin
                r_sh      <= '0;
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_sh <= w_sh_shifted;
                if (r_bit_cnt != c_FULL) begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end
            if (w_complete) begin
                r_data_out <= w_sh_shifted;
            end else if (w_invalid) begin
                r_data_out <= '0;
            end
        end
    end

    assign wait_tx    = r_wait;
    assign eoc_signal = r_eoc;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign busy       = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_serial_receiver
// Brief   : Directed bench for adc_serial_receiver, MSB-first and LSB-first builds.
// Rev     : 1.0  initial release
// ============================================================================
module tb_adc_serial_receiver;

    localparam int c_DW = 12;
    localparam int c_HP = 4;

    logic            clk;
    logic            rst;
    logic            start_m;
    logic            start_l;
    logic            clk_adc;
    logic            adc_dout;
    logic            wait_m, eoc_m, dv_m, busy_m;
    logic            wait_l, eoc_l, dv_l, busy_l;
    logic [c_DW-1:0] dout_m, dout_l;
    logic            sel_lsb;
    int              checks;
    int              errors;
    int              dv_cnt;
    int              dv_pos;

    adc_serial_receiver #(.DATA_WIDTH(c_DW), .HALF_PERIOD(c_HP), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(rst), .start_tx(start_m), .clk_adc(clk_adc), .adc_dout(adc_dout),
        .wait_tx(wait_m), .eoc_signal(eoc_m), .data_out(dout_m), .data_valid(dv_m), .busy(busy_m)
    );

    adc_serial_receiver #(.DATA_WIDTH(c_DW), .HALF_PERIOD(c_HP), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(rst), .start_tx(start_l), .clk_adc(clk_adc), .adc_dout(adc_dout),
        .wait_tx(wait_l), .eoc_signal(eoc_l), .data_out(dout_l), .data_valid(dv_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Acts as the clock generator: each bit is 4 cycles clk_adc high, 4 low.
    // Outputs are sampled on the falling edge just before new inputs are driven.
    task automatic clock_word(input logic [c_DW-1:0] word, input int nbits,
                              output int cnt, output int pos);
        logic b;
        cnt = 0;
        pos = -1;
        for (int i = 0; i < nbits; i++) begin
            b = sel_lsb ? word[i] : word[c_DW-1-i];
            for (int c = 0; c < 2*c_HP; c++) begin
                @(negedge clk);
                if ((sel_lsb ? dv_l : dv_m) === 1'b1) begin
                    cnt = cnt + 1;
                    pos = i*2*c_HP + c;
                end
                if (sel_lsb) start_l = 1'b1;
                else         start_m = 1'b1;
                clk_adc  = (c < c_HP);
                adc_dout = b;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start_m = 1'b0;
        start_l = 1'b0;
        clk_adc = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_m = 1'b0; start_l = 1'b0; clk_adc = 1'b0; adc_dout = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if ({wait_m, eoc_m, dv_m, busy_m, dout_m} !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_msb: got %b_%b_%b_%b_%h required 0", wait_m, eoc_m, dv_m, busy_m, dout_m);
        end
        checks = checks + 1;
        if ({wait_l, eoc_l, dv_l, busy_l, dout_l} !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_lsb: got %b_%b_%b_%b_%h required 0", wait_l, eoc_l, dv_l, busy_l, dout_l);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pacing();
        start_m = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks = checks + 1;
            if (wait_m !== ((k % 4) == 0)) begin
                errors = errors + 1;
                $display("FAIL pacing_cycle%0d: wait_tx=%b required %b", k, wait_m, (k % 4) == 0);
            end
        end
        start_m = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks = checks + 1;
            if (wait_m !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL pacing_idle%0d: wait_tx=%b required 0", k, wait_m);
            end
        end
    endtask

    task automatic test_msb_word();
        sel_lsb = 1'b0;
        clock_word(12'hA5C, 12, dv_cnt, dv_pos);
        checks = checks + 1;
        if (dv_cnt !== 1 || dv_pos !== 89) begin
            errors = errors + 1;
            $display("FAIL msb_valid_timing: count=%0d pos=%0d required 1/89", dv_cnt, dv_pos);
        end
        checks = checks + 1;
        if (dout_m !== 12'hA5C) begin
            errors = errors + 1;
            $display("FAIL msb_data: got %h required a5c", dout_m);
        end
        checks = checks + 1;
        if (eoc_m !== 1'b1 || busy_m !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL msb_done: eoc=%b busy=%b required 1/0", eoc_m, busy_m);
        end
        clock_word(12'hFFF, 2, dv_cnt, dv_pos);
        checks = checks + 1;
        if (dv_cnt !== 0 || dout_m !== 12'hA5C || eoc_m !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL done_ignores_rises: count=%0d data=%h eoc=%b required 0/a5c/1", dv_cnt, dout_m, eoc_m);
        end
        drop_start();
        checks = checks + 1;
        if (eoc_m !== 1'b0 || busy_m !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL msb_eoc_drop: eoc=%b busy=%b required 0/0", eoc_m, busy_m);
        end
    endtask

    task automatic test_lsb_word();
        sel_lsb = 1'b1;
        clock_word(12'h3C1, 12, dv_cnt, dv_pos);
        checks = checks + 1;
        if (dv_cnt !== 1 || dv_pos !== 89 || dout_l !== 12'h3C1) begin
            errors = errors + 1;
            $display("FAIL lsb_word: count=%0d pos=%0d data=%h required 1/89/3c1", dv_cnt, dv_pos, dout_l);
        end
        drop_start();
        checks = checks + 1;
        if (eoc_l !== 1'b0 || dout_m !== 12'hA5C) begin
            errors = errors + 1;
            $display("FAIL lsb_isolation: eoc_l=%b data_m=%h required 0/a5c", eoc_l, dout_m);
        end
        sel_lsb = 1'b0;
    endtask

    task automatic test_abort();
        clock_word(12'hFFF, 5, dv_cnt, dv_pos);
        checks = checks + 1;
        if (busy_m !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL abort_busy: busy=%b required 1", busy_m);
        end
        drop_start();
        checks = checks + 1;
        if (dv_cnt !== 0 || dv_m !== 1'b0 || busy_m !== 1'b0 || eoc_m !== 1'b0 || dout_m !== 12'hA5C) begin
            errors = errors + 1;
            $display("FAIL abort_state: count=%0d dv=%b busy=%b eoc=%b data=%h required 0/0/0/0/a5c",
                     dv_cnt, dv_m, busy_m, eoc_m, dout_m);
        end
        clock_word(12'h5A3, 12, dv_cnt, dv_pos);
        checks = checks + 1;
        if (dv_cnt !== 1 || dout_m !== 12'h5A3) begin
            errors = errors + 1;
            $display("FAIL after_abort_word: count=%0d data=%h required 1/5a3", dv_cnt, dout_m);
        end
        drop_start();
    endtask

    task automatic test_reset_mid();
        clock_word(12'h000, 7, dv_cnt, dv_pos);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if ({wait_m, eoc_m, dv_m, busy_m, dout_m} !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_mid: got %b_%b_%b_%b_%h required 0", wait_m, eoc_m, dv_m, busy_m, dout_m);
        end
        start_m = 1'b0;
        clk_adc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clock_word(12'hFFF, 12, dv_cnt, dv_pos);
        checks = checks + 1;
        if (dv_cnt !== 1 || dout_m !== 12'hFFF) begin
            errors = errors + 1;
            $display("FAIL post_reset_word: count=%0d data=%h required 1/fff", dv_cnt, dout_m);
        end
        drop_start();
    endtask

    task automatic test_back_to_back();
        clock_word(12'h001, 12, dv_cnt, dv_pos);
        checks = checks + 1;
        if (dv_cnt !== 1 || dout_m !== 12'h001) begin
            errors = errors + 1;
            $display("FAIL b2b_first: count=%0d data=%h required 1/001", dv_cnt, dout_m);
        end
        // start_tx low for one cycle only, then straight into the next word.
        @(negedge clk);
        start_m = 1'b0;
        clock_word(12'h800, 12, dv_cnt, dv_pos);
        checks = checks + 1;
        if (dv_cnt !== 1 || dv_pos !== 89 || dout_m !== 12'h800) begin
            errors = errors + 1;
            $display("FAIL b2b_second: count=%0d pos=%0d data=%h required 1/89/800", dv_cnt, dv_pos, dout_m);
        end
        drop_start();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        sel_lsb = 1'b0;
        test_reset();
        test_pacing();
        test_msb_word();
        test_lsb_word();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
